// File: rtl/mmio_periph_if.sv
// Shared data-bus bundle between the core (master) and the MMIO peripheral
// block (slave).
//   mem_read   : read enable, gates read_data
//   mem_write  : write enable
//   address    : byte address
//   write_data : store data, sb/sh payload in the low bytes
//   funct3     : access size ([1] word, else [0] half, else byte)
//   read_data  : read value returned by the peripheral (0 when not reading)
interface mmio_periph_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [2:0]  funct3;
    logic [31:0] read_data;

    modport master (
        output mem_read, mem_write, address, write_data, funct3,
        input  read_data
    );

    modport slave (
        input  mem_read, mem_write, address, write_data, funct3,
        output read_data
    );
endinterface

// File: rtl/mmio_periph.sv
// Memory-mapped peripheral block in the top 64 bytes of the address space.
// Provides NUM_PWM PWM channels with double-buffered duty registers and a
// shared prescaler, free-running MICROS/MILLIS counters and a microsecond
// compare-match timer with a level interrupt.
//   clk       : core clock
//   rst_n     : asynchronous active-low reset
//   bus       : data bus (slave side); read_data is 0 unless mem_read
//   pwm_out   : registered PWM outputs, one per channel
//   irq       : compare interrupt = FLAG & IE
module mmio_periph #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int NUM_PWM     = 4,
    parameter int PWM_BITS    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    mmio_periph_if.slave       bus,
    output logic [NUM_PWM-1:0] pwm_out,
    output logic               irq
);
    localparam int US_DIV = CLK_FREQ_HZ / 1000000;
    localparam int DIV_W  = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(US_DIV - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PWM_BITS-1:0] r_duty   [NUM_PWM];
    logic [PWM_BITS-1:0] r_shadow [NUM_PWM];
    logic [NUM_PWM-1:0]  r_pwm_out;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [15:0]         r_psc;
    logic [15:0]         r_prescale;
    logic                r_en;
    logic [31:0]         r_cmp;
    logic                r_flag;
    logic                r_ie;
    logic [31:0]         r_micros;
    logic [31:0]         r_millis;
    logic [DIV_W-1:0]    r_us_div;
    logic [9:0]          r_ms_sub;
    logic [31:0]         r_rd;

    // ------------------------------------------------------------------
    // Address decode and byte-lane steering
    // ------------------------------------------------------------------
    logic        w_sel;
    logic [3:0]  w_idx;
    logic        w_wr;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_wmask;

    assign w_sel = &bus.address[31:6];
    assign w_idx = bus.address[5:2];
    assign w_wr  = bus.mem_write & w_sel;

    // Sub-word stores arrive in the low bytes; replicate them across all
    // lanes so the byte enables alone pick the destination bytes.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = bus.write_data;
        if (bus.funct3[1]) begin
            w_be    = 4'b1111;
            w_wdata = bus.write_data;
        end else if (bus.funct3[0]) begin
            w_be    = bus.address[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{bus.write_data[15:0]}};
        end else begin
            w_be    = 4'b0001 << bus.address[1:0];
            w_wdata = {4{bus.write_data[7:0]}};
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
        assign w_wmask[gi*8 +: 8] = {8{w_be[gi]}};
    end

    logic w_wr_ctrl;
    logic w_wr_cmp;
    logic w_wr_stat;
    assign w_wr_ctrl = w_wr && (w_idx == 4'd8);
    assign w_wr_cmp  = w_wr && (w_idx == 4'd9);
    assign w_wr_stat = w_wr && (w_idx == 4'd10);

    // ------------------------------------------------------------------
    // Tick generation
    // ------------------------------------------------------------------
    logic        w_psc_tick;
    logic        w_cnt_wrap;
    logic        w_us_tick;
    logic        w_ms_wrap;
    logic [31:0] w_micros_inc;
    logic        w_cmp_hit;
    logic        w_flag_clr;
    logic        w_psc_clr;

    assign w_psc_tick   = (r_psc == r_prescale);
    assign w_cnt_wrap   = w_psc_tick && (r_pwm_cnt == CNT_MAX);
    assign w_us_tick    = (r_us_div == DIV_LAST);
    assign w_ms_wrap    = w_us_tick && (r_ms_sub == 10'd999);
    assign w_micros_inc = r_micros + 32'd1;
    assign w_cmp_hit    = w_us_tick && (w_micros_inc == r_cmp);
    assign w_flag_clr   = w_wr_stat && w_be[0] && w_wdata[0];
    // Only a write touching the PRESCALE bytes restarts the prescaler.
    assign w_psc_clr    = w_wr_ctrl && (w_be[1:0] != 2'b00);

    // ------------------------------------------------------------------
    // Per-channel next values
    // ------------------------------------------------------------------
    logic [PWM_BITS-1:0] w_duty_next [NUM_PWM];
    logic [NUM_PWM-1:0]  w_pwm_next;

    for (genvar gi = 0; gi < NUM_PWM; gi++) begin : g_chan
        logic w_wr_duty;
        assign w_wr_duty = w_wr && (w_idx == 4'(gi));
        assign w_duty_next[gi] = w_wr_duty
            ? ((r_duty[gi] & ~w_wmask[PWM_BITS-1:0]) | (w_wdata[PWM_BITS-1:0] & w_wmask[PWM_BITS-1:0]))
            : r_duty[gi];
        assign w_pwm_next[gi] = r_en & (r_pwm_cnt < r_shadow[gi]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PWM; i++) begin
                r_duty[i]   <= '0;
                r_shadow[i] <= '0;
            end
            r_pwm_out <= '0;
        end else begin
            for (int i = 0; i < NUM_PWM; i++) begin
                r_duty[i] <= w_duty_next[i];
                // Shadow takes the pre-edge duty, so a write landing on the
                // wrap edge waits for the following period.
                if (w_cnt_wrap) begin
                    r_shadow[i] <= r_duty[i];
                end
            end
            r_pwm_out <= w_pwm_next;
        end
    end

    // ------------------------------------------------------------------
    // Control, timer and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt  <= '0;
            r_psc      <= 16'd0;
            r_prescale <= 16'd0;
            r_en       <= 1'b1;
            r_cmp      <= 32'd0;
            r_flag     <= 1'b0;
            r_ie       <= 1'b0;
            r_micros   <= 32'd0;
            r_millis   <= 32'd0;
            r_us_div   <= '0;
            r_ms_sub   <= 10'd0;
        end else begin
            if (w_psc_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
            end
            if (w_psc_tick || w_psc_clr) begin
                r_psc <= 16'd0;
            end else begin
                r_psc <= r_psc + 16'd1;
            end

            if (w_wr_ctrl) begin
                r_prescale <= (r_prescale & ~w_wmask[15:0]) | (w_wdata[15:0] & w_wmask[15:0]);
                if (w_be[3]) begin
                    r_en <= w_wdata[31];
                end
            end

            if (w_wr_cmp) begin
                r_cmp <= (r_cmp & ~w_wmask) | (w_wdata & w_wmask);
            end

            if (w_wr_stat && w_be[0]) begin
                r_ie <= w_wdata[1];
            end
            // A set on the same edge as a W1C wins.
            r_flag <= (r_flag & ~w_flag_clr) | w_cmp_hit;

            if (w_us_tick) begin
                r_us_div <= '0;
                r_micros <= w_micros_inc;
                r_ms_sub <= w_ms_wrap ? 10'd0 : r_ms_sub + 10'd1;
            end else begin
                r_us_div <= r_us_div + 1'b1;
            end
            if (w_ms_wrap) begin
                r_millis <= r_millis + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: capture every edge, gate combinationally with mem_read
    // ------------------------------------------------------------------
    logic [31:0] w_rd_val;

    always_comb begin
        w_rd_val = 32'd0;
        if (w_sel) begin
            case (w_idx)
                4'd8:    w_rd_val = {r_en, 15'd0, r_prescale};
                4'd9:    w_rd_val = r_cmp;
                4'd10:   w_rd_val = {30'd0, r_ie, r_flag};
                4'd13:   w_rd_val = r_micros;
                4'd14:   w_rd_val = r_millis;
                default: begin
                    for (int i = 0; i < NUM_PWM; i++) begin
                        if (w_idx == 4'(i)) begin
                            w_rd_val = 32'(r_duty[i]);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd <= 32'd0;
        end else begin
            r_rd <= w_rd_val;
        end
    end

    assign bus.read_data = bus.mem_read ? r_rd : 32'd0;
    assign pwm_out       = r_pwm_out;
    assign irq           = r_flag & r_ie;
endmodule

// File: tb/tb_mmio_periph.sv
`timescale 1ns/1ps
module tb_mmio_periph;
    localparam int CLK_FREQ_HZ = 12000000;
    localparam int NUM_PWM     = 4;
    localparam int PWM_BITS    = 8;
    localparam int DIV         = CLK_FREQ_HZ / 1000000;
    localparam int STEPS       = 1 << PWM_BITS;
    localparam logic [31:0] BASE = 32'hFFFFFFC0;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [NUM_PWM-1:0] pwm_out;
    logic               irq;

    mmio_periph_if bus();

    mmio_periph #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .NUM_PWM    (NUM_PWM),
        .PWM_BITS   (PWM_BITS)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .pwm_out(pwm_out),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, expv, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: register file plus elapsed-cycle arithmetic
    // ------------------------------------------------------------------
    int          m_duty   [NUM_PWM];
    int          m_shadow [NUM_PWM];
    int          m_prescale, m_psc, m_cnt;
    bit          m_en;
    logic [31:0] m_cmp;
    logic [31:0] m_off;       // MICROS = m_off + elapsed ticks
    bit          m_flag, m_ie;
    longint      m_cyc;       // active edges since reset release
    logic [31:0] exp_rd;
    logic [NUM_PWM-1:0] exp_pwm;

    function automatic logic [31:0] m_micros();
        return m_off + 32'(m_cyc / DIV);
    endfunction

    function automatic logic [31:0] m_millis();
        return 32'((m_cyc / DIV) / 1000);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int w;
        if (a[31:6] != 26'h3FFFFFF) return 32'd0;
        w = int'(a[5:2]);
        if (w < NUM_PWM) return 32'(m_duty[w]);
        case (w)
            8:  return (m_en ? 32'h80000000 : 32'h0) | 32'(m_prescale);
            9:  return m_cmp;
            10: return {30'd0, m_ie, m_flag};
            13: return m_micros();
            14: return m_millis();
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_PWM; i++) begin
            m_duty[i] = 0;
            m_shadow[i] = 0;
        end
        m_prescale = 0; m_psc = 0; m_cnt = 0; m_en = 1;
        m_cmp = 0; m_off = 0; m_flag = 0; m_ie = 0; m_cyc = 0;
        exp_rd = 0; exp_pwm = '0;
    endtask

    task automatic model_edge();
        logic [31:0] nv;
        logic [3:0]  be;
        logic [7:0]  bv;
        bit          hit, clr;
        int          w;
        exp_rd = model_read(bus.address);
        for (int i = 0; i < NUM_PWM; i++) exp_pwm[i] = m_en && (m_cnt < m_shadow[i]);
        if (m_psc == m_prescale) begin
            m_psc = 0;
            m_cnt = (m_cnt + 1) % STEPS;
            if (m_cnt == 0)
                for (int i = 0; i < NUM_PWM; i++) m_shadow[i] = m_duty[i];
        end else begin
            m_psc++;
        end
        m_cyc++;
        hit = ((m_cyc % DIV) == 0) && (m_micros() == m_cmp);
        clr = 0;
        if (bus.mem_write && bus.address[31:6] == 26'h3FFFFFF) begin
            nv = model_read(bus.address);
            for (int k = 0; k < 4; k++) begin
                if (bus.funct3[1]) begin
                    be[k] = 1'b1; bv = bus.write_data[8*k +: 8];
                end else if (bus.funct3[0]) begin
                    be[k] = ((k / 2) == int'(bus.address[1])); bv = bus.write_data[8*(k%2) +: 8];
                end else begin
                    be[k] = (k == int'(bus.address[1:0])); bv = bus.write_data[7:0];
                end
                if (be[k]) nv[8*k +: 8] = bv;
            end
            w = int'(bus.address[5:2]);
            if (w < NUM_PWM) m_duty[w] = int'(nv) & (STEPS - 1);
            else if (w == 8) begin
                m_prescale = int'(nv[15:0]);
                m_en = nv[31];
                if (be[0] || be[1]) m_psc = 0;
            end else if (w == 9) m_cmp = nv;
            else if (w == 10 && be[0]) begin
                m_ie = nv[1];
                clr = nv[0];
            end
        end
        m_flag = (m_flag && !clr) || hit;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_edge();
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("pwm_out", 32'(pwm_out), 32'(exp_pwm));
                chk("irq", 32'(irq), 32'(m_flag && m_ie));
                chk("read_data", bus.read_data, bus.mem_read ? exp_rd : 32'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_bus(input bit r, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] f);
        bus.mem_read = r; bus.mem_write = w; bus.address = a;
        bus.write_data = d; bus.funct3 = f;
    endtask

    task automatic drive(input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f);
        @(posedge clk); #2;
        set_bus(r, w, a, d, f);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 32'd0, 32'd0, 3'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        drive(0, 1, a, d, f);
        idle(1);
    endtask

    task automatic read_lit(input logic [31:0] a, input logic [31:0] expv, input string name);
        drive(1, 0, a, 32'd0, 3'b010);
        drive(1, 0, a, 32'd0, 3'b010);
        @(negedge clk);
        chk(name, bus.read_data, expv);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        set_bus(0, 0, 32'd0, 32'd0, 3'd0);
        @(negedge clk);
        chk("pwm_in_reset", 32'(pwm_out), 32'd0);
        chk("irq_in_reset", 32'(irq), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic count_high(input int ch, input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (pwm_out[ch]) cnt++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    int  cnt;
    bit  found;
    logic [31:0] ra, rdat;

    initial begin
        set_bus(0, 0, 32'd0, 32'd0, 3'd0);
        #1 rst_n = 1'b0;
        chk_on = 1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset value of PWM_CTRL
        read_lit(BASE + 32'h20, 32'h80000000, "ctrl_reset");
        read_lit(BASE + 32'h28, 32'h00000000, "status_reset");

        // Time base from a fresh reset
        do_reset();
        set_bus(1, 0, BASE + 32'h34, 32'd0, 3'b010);
        repeat (12) @(posedge clk);
        @(negedge clk); chk("micros_before_tick", bus.read_data, 32'd0);
        @(posedge clk);
        @(negedge clk); chk("micros_12cyc", bus.read_data, 32'd1);
        repeat (12001 - 13) @(posedge clk);
        @(negedge clk); chk("micros_12000cyc", bus.read_data, 32'd1000);
        #1 bus.address = BASE + 32'h38;
        @(posedge clk);
        @(negedge clk); chk("millis_12000cyc", bus.read_data, 32'd1);

        // PWM duty and double buffering
        do_reset();
        wr(BASE + 32'h00, 32'h40, 3'b010);
        idle(600);
        count_high(0, 256, cnt); chk("pwm_duty_64", 32'(cnt), 32'd64);
        wr(BASE + 32'h00, 32'h80, 3'b010);
        idle(300);
        count_high(0, 256, cnt); chk("pwm_duty_128", 32'(cnt), 32'd128);
        wr(BASE + 32'h04, 32'hFF, 3'b010);
        idle(300);
        count_high(1, 256, cnt); chk("pwm_duty_max", 32'(cnt), 32'd255);
        count_high(2, 256, cnt); chk("pwm_duty_zero", 32'(cnt), 32'd0);

        // Byte lanes and reserved offsets
        do_reset();
        wr(BASE + 32'h04, 32'hAB, 3'b000);
        read_lit(BASE + 32'h04, 32'h000000AB, "sb_duty_byte0");
        wr(BASE + 32'h05, 32'hCD, 3'b000);
        read_lit(BASE + 32'h04, 32'h000000AB, "sb_duty_byte1");
        wr(BASE + 32'h04 + 32'(4 * NUM_PWM), 32'hFFFFFFFF, 3'b010);
        read_lit(BASE + 32'h04 + 32'(4 * NUM_PWM), 32'h0, "unimpl_duty");
        wr(BASE + 32'h26, 32'h00001234, 3'b001);
        read_lit(BASE + 32'h24, 32'h12340000, "sh_cmp_hi");
        wr(BASE + 32'h24, 32'hBEEF5678, 3'b001);
        read_lit(BASE + 32'h24, 32'h12345678, "sh_cmp_lo");
        wr(BASE + 32'h23, 32'h00000000, 3'b000);
        read_lit(BASE + 32'h20, 32'h00000000, "sb_ctrl_en_off");

        // Randomised traffic with one reset in the middle
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            ra   = ($urandom_range(0, 9) == 0) ? $urandom : (BASE | 32'($urandom_range(0, 63)));
            rdat = $urandom;
            drive(bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ra, rdat,
                  3'($urandom_range(0, 7)));
        end
        idle(2);

        // Compare match and interrupt
        wr(BASE + 32'h20, 32'h80000000, 3'b010);
        wr(BASE + 32'h28, 32'h3, 3'b010);
        wr(BASE + 32'h24, m_micros() + 32'd5, 3'b010);
        found = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (irq) found = 1;
        end
        chk("irq_rise", 32'(found), 32'd1);
        read_lit(BASE + 32'h28, 32'h3, "status_flag_ie");
        drive(0, 1, BASE + 32'h28, 32'h3, 3'b000);
        idle(1);
        @(negedge clk); chk("irq_w1c", 32'(irq), 32'd0);

        // W1C landing on the setting edge
        wr(BASE + 32'h24, m_micros() + 32'd3, 3'b010);
        found = 0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(posedge clk); #2;
            if (((m_cyc + 1) % DIV == 0) && (m_micros() + 32'd1 == m_cmp)) begin
                set_bus(0, 1, BASE + 32'h28, 32'h3, 3'b010);
                found = 1;
            end else begin
                set_bus(0, 0, 32'd0, 32'd0, 3'd0);
            end
        end
        chk("coincide_found", 32'(found), 32'd1);
        idle(1);
        @(negedge clk); chk("set_wins_w1c", 32'(irq), 32'd1);

        // MICROS wrap with CMP = 0
        wr(BASE + 32'h24, 32'h0, 3'b010);
        wr(BASE + 32'h28, 32'h3, 3'b010);
        read_lit(BASE + 32'h28, 32'h2, "flag_cleared");
        @(posedge clk); #2;
        force dut.r_micros = 32'hFFFFFFFF;
        m_off = 32'hFFFFFFFF - 32'(m_cyc / DIV);
        #1 release dut.r_micros;
        idle(DIV + 2);
        read_lit(BASE + 32'h28, 32'h3, "wrap_flag");
        drive(1, 0, BASE + 32'h34, 32'd0, 3'b010);
        drive(1, 0, BASE + 32'h34, 32'd0, 3'b010);
        @(negedge clk); chk("micros_wrapped_small", 32'(bus.read_data < 32'd4), 32'd1);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
